// File: rtl/outstream_pkg.sv
// Shared FSM state encoding and dataflow mode constants for the tiled output stream.
package outstream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/outstream_acc_cell.sv
// One result-buffer element: clear, overwrite or accumulate (modulo 2^WIDTH).
module outstream_acc_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr,
    input  logic             acc,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (wr) begin
            q <= acc ? q + din : din;
        end
    end

endmodule

// File: rtl/outstream_tiled.sv
// Captures skewed (WS) or row-reversed (OS) array output lanes into an MxN buffer,
// then drains it one row per accepted out_valid/out_ready handshake.
module outstream_tiled
    import outstream_pkg::*;
#(
    parameter int SYS_ARR_SIZE = 8,
    parameter int PE_OUT_WIDTH = 32,
    parameter int DIM_WIDTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 mode,
    input  logic                                 acc_en,
    input  logic [DIM_WIDTH-1:0]                 M,
    input  logic [DIM_WIDTH-1:0]                 N,
    input  logic [DIM_WIDTH-1:0]                 SKEW,
    input  logic [SYS_ARR_SIZE*PE_OUT_WIDTH-1:0] result_in,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SYS_ARR_SIZE*PE_OUT_WIDTH-1:0] out_data,
    output logic [DIM_WIDTH-1:0]                 out_row,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int SA = SYS_ARR_SIZE;
    localparam int LW = PE_OUT_WIDTH;
    localparam int CW = DIM_WIDTH + 1;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   mode_q, acc_q, err_q;
    logic [DIM_WIDTH-1:0]   m_q, n_q, skew_q;
    logic [CW-1:0]          m_ext, n_ext, cap_len;
    logic                   dims_ok, start_ok, clr_all, capturing, drain_last;
    logic [LW-1:0]          cell_q [SA][SA];

    assign dims_ok = (M != '0) && (N != '0) &&
                     ({1'b0, M} <= CW'(SA)) && ({1'b0, N} <= CW'(SA));
    assign start_ok  = (state == ST_IDLE) && start && dims_ok;
    assign clr_all   = start_ok && !acc_en;
    assign capturing = (state == ST_CAPTURE);

    assign m_ext   = {1'b0, m_q};
    assign n_ext   = {1'b0, n_q};
    assign cap_len = (mode_q == MODE_WS) ? (m_ext + n_ext - CW'(1)) : m_ext;

    // One counter serves as wait timer, capture index t and drain row index.
    assign drain_last = (cnt == m_ext - CW'(1));

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    cnt_nx   = '0;
                    state_nx = (SKEW == '0) ? ST_CAPTURE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == {1'b0, skew_q} - CW'(1)) begin
                    cnt_nx   = '0;
                    state_nx = ST_CAPTURE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_CAPTURE: begin
                if (cnt == cap_len - CW'(1)) begin
                    cnt_nx   = '0;
                    state_nx = ST_DRAIN;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (drain_last) begin
                        cnt_nx   = '0;
                        state_nx = ST_DONE;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            acc_q  <= 1'b0;
            m_q    <= '0;
            n_q    <= '0;
            skew_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= (state == ST_IDLE) && start && !dims_ok;
            if (start_ok) begin
                mode_q <= mode;
                acc_q  <= acc_en;
                m_q    <= M;
                n_q    <= N;
                skew_q <= SKEW;
            end
        end
    end

    // WS: cell (i,j) is written when i+j == t. OS: row i is written when i == M-1-t.
    for (genvar i = 0; i < SA; i++) begin : g_row
        for (genvar j = 0; j < SA; j++) begin : g_col
            logic row_hit, cell_wr;
            assign row_hit = (mode_q == MODE_WS) ? (cnt == CW'(i + j))
                                                 : (m_ext - CW'(1) - cnt == CW'(i));
            assign cell_wr = capturing && row_hit && (CW'(i) < m_ext) && (CW'(j) < n_ext);

            outstream_acc_cell #(.WIDTH(LW)) u_cell (
                .clk   (clk),
                .reset (reset),
                .clr   (clr_all),
                .wr    (cell_wr),
                .acc   (acc_q),
                .din   (result_in[j*LW +: LW]),
                .q     (cell_q[i][j])
            );
        end
    end

    assign out_valid = (state == ST_DRAIN);
    assign out_row   = out_valid ? cnt[DIM_WIDTH-1:0] : '0;
    assign out_last  = out_valid && drain_last;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign err       = err_q;

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int i = 0; i < SA; i++) begin
                if (cnt == CW'(i)) begin
                    for (int j = 0; j < SA; j++) begin
                        if (CW'(j) < n_ext) begin
                            out_data[j*LW +: LW] = cell_q[i][j];
                        end
                    end
                end
            end
        end
    end

endmodule
